// File: rtl/fwft_word_serializer_if.sv
// Bus bundle for fwft_word_serializer.
//  master : serializer side (pops the FIFO, drives the chunk stream)
//  slave  : environment side (FIFO head + stream sink)
// Signals: fifo_empty, fifo_data, fifo_read, out_data, out_valid,
//          out_ready, out_last, busy.
interface fwft_word_serializer_if #(
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned OUT_WIDTH = 8
);
   logic                 fifo_empty;
   logic [IN_WIDTH-1:0]  fifo_data;
   logic                 fifo_read;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_last;
   logic                 busy;

   modport master (
      input  fifo_empty, fifo_data, out_ready,
      output fifo_read, out_data, out_valid, out_last, busy
   );

   modport slave (
      output fifo_empty, fifo_data, out_ready,
      input  fifo_read, out_data, out_valid, out_last, busy
   );
endinterface

// File: rtl/fwft_word_serializer.sv
// Read side of the FWFT FIFO: pops IN_WIDTH-bit words and emits them as
// IN_WIDTH/OUT_WIDTH chunks, MSB chunk first, on a valid/ready stream.
// Back-to-back words stream without bubbles (reload on the last transfer).
// Ports:
//  clk  : rising-edge clock
//  resn : synchronous active-low reset
//  bus  : fwft_word_serializer_if.master (FIFO pop side + chunk stream)
// Build option: FWFT_SERIALIZER_IDLE_FILL_EN -- when defined, IDLE presents
// IDLE_PATTERN filler chunks and an IDLE load needs a filler transfer.
module fwft_word_serializer #(
   parameter int unsigned          IN_WIDTH     = 32,
   parameter int unsigned          OUT_WIDTH    = 8,
   parameter logic [OUT_WIDTH-1:0] IDLE_PATTERN = 8'hBC
) (
   input logic                    clk,
   input logic                    resn,
   fwft_word_serializer_if.master bus
);

   localparam int unsigned NCHUNK = IN_WIDTH / OUT_WIDTH;
   localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   state_e              state_q;
   logic [IN_WIDTH-1:0] shift_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                last_q;

   logic idle_c;
   logic send_c;
   logic idle_pop_ok_c;
   logic xfer_c;
   logic fifo_read_c;

   // Pop strobe: load from IDLE, or reload on the final chunk's transfer.
   always_comb begin
      idle_c = (state_q == ST_IDLE);
      send_c = (state_q == ST_SEND);
`ifdef FWFT_SERIALIZER_IDLE_FILL_EN
      // The filler chunk must be consumed in the same cycle as the pop.
      idle_pop_ok_c = bus.out_ready;
`else
      idle_pop_ok_c = 1'b1;
`endif
      xfer_c      = send_c & bus.out_ready;
      fifo_read_c = resn & ~bus.fifo_empty &
                    ((idle_c & idle_pop_ok_c) | (xfer_c & last_q));
   end

   // State, shift register, chunk counter and registered last flag.
   always_ff @(posedge clk) begin
      if (!resn) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
      end else if (fifo_read_c) begin
         state_q <= ST_SEND;
         shift_q <= bus.fifo_data;
         cnt_q   <= '0;
         last_q  <= (NCHUNK == 1);
      end else if (xfer_c) begin
         if (last_q) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b0;
         end else begin
            shift_q <= shift_q << OUT_WIDTH;
            cnt_q   <= cnt_q + CNT_W'(1);
            // Flag the chunk that becomes current after this shift.
            last_q  <= ((32'(cnt_q) + 32'd1) == (NCHUNK - 32'd1));
         end
      end
   end

   assign bus.fifo_read = fifo_read_c;
   assign bus.out_data  = send_c ? shift_q[IN_WIDTH-1 -: OUT_WIDTH] : IDLE_PATTERN;
   assign bus.out_last  = last_q;
   assign bus.busy      = send_c;

`ifdef FWFT_SERIALIZER_IDLE_FILL_EN
   // Filler is offered in IDLE whenever reset is released.
   assign bus.out_valid = send_c | (idle_c & resn);
`else
   assign bus.out_valid = send_c;
`endif

endmodule

// File: tb/tb_fwft_word_serializer.sv
// Self-checking bench for fwft_word_serializer: directed timing scenarios
// plus randomized streaming against a chunk-queue reference model.
module tb_fwft_word_serializer;

   localparam int unsigned IW = 32;
   localparam int unsigned OW = 8;
   localparam int unsigned NC = IW / OW;
   localparam logic [OW-1:0] IDLE_PAT = 8'hBC;
`ifdef FWFT_SERIALIZER_IDLE_FILL_EN
   localparam bit FILL = 1'b1;
`else
   localparam bit FILL = 1'b0;
`endif

   logic clk  = 1'b0;
   logic resn = 1'b0;

   fwft_word_serializer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bif ();

   fwft_word_serializer #(
      .IN_WIDTH    (IW),
      .OUT_WIDTH   (OW),
      .IDLE_PATTERN(IDLE_PAT)
   ) dut (
      .clk (clk),
      .resn(resn),
      .bus (bif)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int npops = 0;

   logic [IW-1:0] fifoq[$];

   logic          s_rd, s_valid, s_last, s_busy, s_ready, s_empty;
   logic [OW-1:0] s_data;

   // k-th chunk of a word, MSB chunk first.
   function automatic logic [OW-1:0] chunk_of(input logic [IW-1:0] w, input int k);
      return OW'(w >> (OW * (NC - 1 - k)));
   endfunction

   // Present the FIFO head (junk data when empty).
   task automatic fifo_drive();
      bif.fifo_empty = (fifoq.size() == 0);
      bif.fifo_data  = (fifoq.size() != 0) ? fifoq[0] : IW'($urandom);
   endtask

   // Sample outputs mid-cycle, then advance one clock and apply any pop.
   task automatic tick();
      @(negedge clk);
      s_rd    = bif.fifo_read;
      s_valid = bif.out_valid;
      s_last  = bif.out_last;
      s_busy  = bif.busy;
      s_data  = bif.out_data;
      s_ready = bif.out_ready;
      s_empty = bif.fifo_empty;
      total++;
      if (s_rd === 1'b1 && (s_empty === 1'b1 || resn === 1'b0)) begin
         bad++;
         $display("FAIL pop_guard: fifo_read=%b with empty=%b resn=%b, required fifo_read=0",
                  s_rd, s_empty, resn);
      end
      @(posedge clk);
      #1;
      if (s_rd === 1'b1) begin
         npops++;
         if (fifoq.size() != 0) void'(fifoq.pop_front());
      end
      fifo_drive();
   endtask

   task automatic test_reset();
      resn          = 1'b0;
      bif.out_ready = 1'b1;
      fifoq         = {32'hDEADBEEF};
      fifo_drive();
      repeat (2) begin
         tick();
         total++;
         if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_last !== 1'b0 || s_rd !== 1'b0) begin
            bad++;
            $display("FAIL reset: valid=%b busy=%b last=%b rd=%b, required all 0",
                     s_valid, s_busy, s_last, s_rd);
         end
      end
      resn = 1'b1;
   endtask

   task automatic test_single();
      logic [IW-1:0] w;
      w = 32'hDEADBEEF;
      tick();
      total++;
      if (s_rd !== 1'b1 || s_valid !== FILL || s_busy !== 1'b0) begin
         bad++;
         $display("FAIL single_load: rd=%b valid=%b busy=%b, required rd=1 valid=%b busy=0",
                  s_rd, s_valid, s_busy, FILL);
      end
      for (int k = 0; k < int'(NC); k++) begin
         tick();
         total++;
         if (s_valid !== 1'b1 || s_data !== chunk_of(w, k) || s_last !== (k == int'(NC) - 1) ||
             s_busy !== 1'b1 || s_rd !== 1'b0) begin
            bad++;
            $display("FAIL single_chunk%0d: valid=%b data=%h last=%b busy=%b rd=%b, required 1 %h %b 1 0",
                     k, s_valid, s_data, s_last, s_busy, s_rd, chunk_of(w, k), (k == int'(NC) - 1));
         end
      end
      tick();
      total++;
      if (s_valid !== FILL || s_busy !== 1'b0 || (FILL && s_data !== IDLE_PAT)) begin
         bad++;
         $display("FAIL single_idle: valid=%b busy=%b data=%h, required valid=%b busy=0",
                  s_valid, s_busy, s_data, FILL);
      end
   endtask

   task automatic test_back_to_back();
      logic [IW-1:0] w[2];
      w[0] = 32'h01020304;
      w[1] = 32'hA0B0C0D0;
      fifoq = {w[0], w[1]};
      fifo_drive();
      bif.out_ready = 1'b1;
      tick();
      total++;
      if (s_rd !== 1'b1) begin
         bad++;
         $display("FAIL b2b_load: rd=%b, required 1", s_rd);
      end
      for (int k = 0; k < 2 * int'(NC); k++) begin
         tick();
         total++;
         if (s_valid !== 1'b1 || s_data !== chunk_of(w[k / int'(NC)], k % int'(NC)) ||
             s_last !== ((k % int'(NC)) == int'(NC) - 1) || s_rd !== (k == int'(NC) - 1)) begin
            bad++;
            $display("FAIL b2b_chunk%0d: valid=%b data=%h last=%b rd=%b, required 1 %h %b %b",
                     k, s_valid, s_data, s_last, s_rd, chunk_of(w[k / int'(NC)], k % int'(NC)),
                     ((k % int'(NC)) == int'(NC) - 1), (k == int'(NC) - 1));
         end
      end
      tick();
      total++;
      if (s_valid !== FILL || s_busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_idle: valid=%b busy=%b, required valid=%b busy=0", s_valid, s_busy, FILL);
      end
   endtask

   // Streaming scenario: mode 0 uses a fixed 1,0,0,1,1 ready pattern,
   // mode 1 random ready. Every accepted word chunk is scored in order.
   task automatic run_stream(input int ncyc, input bit rnd, input int push_pct);
      logic [OW-1:0] expq[$];
      bit            pat[5];
      int            kidx, pushed, pops0, c;
      bit            prev_hold;
      logic [OW-1:0] prev_data, exp_d;
      logic          prev_last;
      pat       = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      kidx      = 0;
      pushed    = 0;
      pops0     = npops;
      prev_hold = 1'b0;
      prev_data = '0;
      prev_last = 1'b0;
      c         = 0;
      while (c < ncyc + 400) begin
         if (c >= ncyc && expq.size() == 0) break;
         if (c >= ncyc) bif.out_ready = 1'b1;
         else if (rnd) bif.out_ready = 1'($urandom_range(0, 1));
         else bif.out_ready = pat[c % 5];
         if (c < ncyc && fifoq.size() < 4 && $urandom_range(0, 99) < push_pct) begin
            logic [IW-1:0] w;
            w = IW'($urandom);
            fifoq.push_back(w);
            for (int k = 0; k < int'(NC); k++) expq.push_back(chunk_of(w, k));
            pushed++;
         end
         fifo_drive();
         tick();
         if (prev_hold) begin
            total++;
            if (s_valid !== 1'b1 || s_data !== prev_data || s_last !== prev_last) begin
               bad++;
               $display("FAIL hold: valid=%b data=%h last=%b, required 1 %h %b",
                        s_valid, s_data, s_last, prev_data, prev_last);
            end
         end
         if (!FILL) begin
            total++;
            if (s_busy !== s_valid) begin
               bad++;
               $display("FAIL busy_valid: busy=%b valid=%b, required equal", s_busy, s_valid);
            end
         end
         if (s_valid === 1'b1 && s_ready === 1'b1 && s_busy === 1'b1) begin
            total++;
            if (expq.size() == 0) begin
               bad++;
               $display("FAIL extra_chunk: data=%h, required no transfer", s_data);
            end else begin
               exp_d = expq.pop_front();
               if (s_data !== exp_d || s_last !== (kidx == int'(NC) - 1)) begin
                  bad++;
                  $display("FAIL stream_chunk: data=%h last=%b, required %h %b",
                           s_data, s_last, exp_d, (kidx == int'(NC) - 1));
               end
            end
            kidx = (kidx + 1) % int'(NC);
         end
         prev_hold = (s_valid === 1'b1 && s_ready === 1'b0 && s_busy === 1'b1);
         prev_data = s_data;
         prev_last = s_last;
         c++;
      end
      total++;
      if (expq.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d chunks left, required 0", expq.size());
      end
      total++;
      if (npops - pops0 != pushed) begin
         bad++;
         $display("FAIL pop_count: pops=%0d, required %0d", npops - pops0, pushed);
      end
   endtask

   task automatic test_backpressure();
      run_stream(40, 1'b0, 30);
   endtask

   task automatic test_random();
      run_stream(600, 1'b1, 25);
   endtask

   task automatic test_reset_mid();
      logic [IW-1:0] w1;
      w1 = 32'h55667788;
      fifoq = {32'h11223344, w1};
      fifo_drive();
      bif.out_ready = 1'b1;
      repeat (3) tick();  // load, 11, 22
      resn = 1'b0;
      tick();
      total++;
      if (s_rd !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_rd: rd=%b, required 0", s_rd);
      end
      tick();
      total++;
      if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_rd !== 1'b0 || fifoq.size() != 1) begin
         bad++;
         $display("FAIL rstmid_state: valid=%b busy=%b rd=%b fifo=%0d, required 0 0 0 1",
                  s_valid, s_busy, s_rd, fifoq.size());
      end
      resn = 1'b1;
      tick();
      total++;
      if (s_rd !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_reload: rd=%b, required 1", s_rd);
      end
      for (int k = 0; k < int'(NC); k++) begin
         tick();
         total++;
         if (s_valid !== 1'b1 || s_data !== chunk_of(w1, k) || s_last !== (k == int'(NC) - 1)) begin
            bad++;
            $display("FAIL rstmid_chunk%0d: valid=%b data=%h last=%b, required 1 %h %b",
                     k, s_valid, s_data, s_last, chunk_of(w1, k), (k == int'(NC) - 1));
         end
      end
   endtask

   task automatic test_empty();
      fifoq = {};
      for (int i = 0; i < 16; i++) begin
         bif.out_ready = 1'($urandom_range(0, 1));
         fifo_drive();
         tick();
         total++;
         if (s_rd !== 1'b0 || s_valid !== FILL || s_busy !== 1'b0 ||
             (FILL && (s_data !== IDLE_PAT || s_last !== 1'b0))) begin
            bad++;
            $display("FAIL empty: rd=%b valid=%b busy=%b data=%h, required rd=0 valid=%b busy=0",
                     s_rd, s_valid, s_busy, s_data, FILL);
         end
      end
   endtask

`ifdef FWFT_SERIALIZER_IDLE_FILL_EN
   task automatic test_idle_fill();
      logic [IW-1:0] w;
      w = 32'hCAFEF00D;
      bif.out_ready = 1'b1;
      fifoq = {};
      fifo_drive();
      repeat (3) begin
         tick();
         total++;
         if (s_valid !== 1'b1 || s_data !== IDLE_PAT || s_rd !== 1'b0) begin
            bad++;
            $display("FAIL fill_idle: valid=%b data=%h rd=%b, required 1 %h 0", s_valid, s_data, s_rd, IDLE_PAT);
         end
      end
      fifoq = {w};
      fifo_drive();
      tick();
      total++;
      if (s_valid !== 1'b1 || s_data !== IDLE_PAT || s_rd !== 1'b1 || s_busy !== 1'b0) begin
         bad++;
         $display("FAIL fill_load: valid=%b data=%h rd=%b busy=%b, required 1 %h 1 0",
                  s_valid, s_data, s_rd, s_busy, IDLE_PAT);
      end
      for (int k = 0; k < int'(NC); k++) begin
         tick();
         total++;
         if (s_valid !== 1'b1 || s_data !== chunk_of(w, k) || s_last !== (k == int'(NC) - 1)) begin
            bad++;
            $display("FAIL fill_chunk%0d: data=%h last=%b, required %h %b",
                     k, s_data, s_last, chunk_of(w, k), (k == int'(NC) - 1));
         end
      end
      tick();
      total++;
      if (s_valid !== 1'b1 || s_data !== IDLE_PAT || s_last !== 1'b0 || s_busy !== 1'b0) begin
         bad++;
         $display("FAIL fill_resume: valid=%b data=%h last=%b busy=%b, required 1 %h 0 0",
                  s_valid, s_data, s_last, s_busy, IDLE_PAT);
      end
   endtask
`endif

   initial begin
      bif.out_ready  = 1'b1;
      bif.fifo_empty = 1'b1;
      bif.fifo_data  = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_empty();
`ifdef FWFT_SERIALIZER_IDLE_FILL_EN
      test_idle_fill();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
